// File: rtl/ps2_synth_pkg.sv
// Shared scan codes, lookup helpers, parser state and ADSR selector encodings
// for the PS/2 synth keyboard front end.
package ps2_synth_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam logic [7:0] SC_Z   = 8'h1A;
    localparam logic [7:0] SC_X   = 8'h22;
    localparam logic [7:0] SC_C   = 8'h21;
    localparam logic [7:0] SC_V   = 8'h2A;
    localparam logic [7:0] SC_1   = 8'h16;
    localparam logic [7:0] SC_2   = 8'h1E;
    localparam logic [7:0] SC_3   = 8'h26;
    localparam logic [7:0] SC_4   = 8'h25;
    localparam logic [7:0] SC_5   = 8'h2E;
    localparam logic [7:0] SC_6   = 8'h36;
    localparam logic [7:0] SC_7   = 8'h3D;
    localparam logic [7:0] SC_8   = 8'h3E;
    localparam logic [7:0] SC_TAB = 8'h0D;

    // Held-bit slots for control keys that ignore typematic repeats
    localparam logic [2:0] H_Z   = 3'd0;
    localparam logic [2:0] H_X   = 3'd1;
    localparam logic [2:0] H_C   = 3'd2;
    localparam logic [2:0] H_V   = 3'd3;
    localparam logic [2:0] H_6   = 3'd4;
    localparam logic [2:0] H_7   = 3'd5;
    localparam logic [2:0] H_8   = 3'd6;
    localparam logic [2:0] H_TAB = 3'd7;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_BRK     = 2'd1,
        PS_EXT     = 2'd2,
        PS_EXT_BRK = 2'd3
    } ps_state_e;

    typedef enum logic [2:0] {
        ADSR_VOL = 3'd0,
        ADSR_A   = 3'd1,
        ADSR_D   = 3'd2,
        ADSR_S   = 3'd3,
        ADSR_R   = 3'd4
    } adsr_sel_e;

    // Returns {hit, note index 0..11}
    function automatic logic [4:0] note_lookup(input logic [7:0] code);
        case (code)
            8'h1C:   return {1'b1, 4'd0};
            8'h1D:   return {1'b1, 4'd1};
            8'h1B:   return {1'b1, 4'd2};
            8'h24:   return {1'b1, 4'd3};
            8'h23:   return {1'b1, 4'd4};
            8'h2B:   return {1'b1, 4'd5};
            8'h2C:   return {1'b1, 4'd6};
            8'h34:   return {1'b1, 4'd7};
            8'h35:   return {1'b1, 4'd8};
            8'h33:   return {1'b1, 4'd9};
            8'h3C:   return {1'b1, 4'd10};
            8'h3B:   return {1'b1, 4'd11};
            default: return 5'd0;
        endcase
    endfunction

    // Returns {hit, held-bit index}
    function automatic logic [3:0] ctl_lookup(input logic [7:0] code);
        case (code)
            SC_Z:    return {1'b1, H_Z};
            SC_X:    return {1'b1, H_X};
            SC_C:    return {1'b1, H_C};
            SC_V:    return {1'b1, H_V};
            SC_6:    return {1'b1, H_6};
            SC_7:    return {1'b1, H_7};
            SC_8:    return {1'b1, H_8};
            SC_TAB:  return {1'b1, H_TAB};
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_voice_alloc.sv
// Voice slot allocator: maps note make/break strobes onto NUM_VOICES slots
// with lowest-free allocation, round-robin stealing and sustain-hold support.
module ps2_voice_alloc #(
    parameter int NUM_VOICES = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    note_make,
    input  logic                    note_brk,
    input  logic [3:0]              note,
    input  logic                    hold,
    input  logic                    hold_fall,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_trig
);
    localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NUM_VOICES-1:0][3:0] note_q, note_d;
    logic [NUM_VOICES-1:0]      gate_q, gate_d;
    logic [NUM_VOICES-1:0]      phys_q, phys_d;
    logic [NUM_VOICES-1:0]      trig_q, trig_d;
    logic [PW-1:0]              steal_q, steal_d;

    logic [NUM_VOICES-1:0] match, free;
    logic [PW-1:0]         m_idx, f_idx, sel;

    always_comb begin
        m_idx = '0;
        f_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            match[i] = gate_q[i] && (note_q[i] == note);
            free[i]  = !gate_q[i];
        end
        // Descending scan so the lowest matching/free index wins
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (match[i]) m_idx = PW'(i);
            if (free[i])  f_idx = PW'(i);
        end
        sel = (|free) ? f_idx : steal_q;
    end

    always_comb begin
        note_d  = note_q;
        gate_d  = gate_q;
        phys_d  = phys_q;
        trig_d  = '0;
        steal_d = steal_q;
        if (note_make) begin
            if (|match) begin
                phys_d[m_idx] = 1'b1;
            end else begin
                note_d[sel] = note;
                gate_d[sel] = 1'b1;
                phys_d[sel] = 1'b1;
                trig_d[sel] = 1'b1;
                if (!(|free))
                    steal_d = (steal_q == PW'(NUM_VOICES - 1)) ? '0 : steal_q + PW'(1);
            end
        end
        if (note_brk && (|match)) begin
            phys_d[m_idx] = 1'b0;
            if (!hold) gate_d[m_idx] = 1'b0;
        end
        // Releasing sustain drops every slot whose key is no longer down
        if (hold_fall) gate_d = gate_d & phys_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            note_q  <= '0;
            gate_q  <= '0;
            phys_q  <= '0;
            trig_q  <= '0;
            steal_q <= '0;
        end else begin
            note_q  <= note_d;
            gate_q  <= gate_d;
            phys_q  <= phys_d;
            trig_q  <= trig_d;
            steal_q <= steal_d;
        end
    end

    assign voice_note = note_q;
    assign voice_gate = gate_q;
    assign voice_trig = trig_q;

endmodule

// File: rtl/ps2_poly_keymap.sv
// Polyphonic PS/2 keyboard decoder: scan-code parser, control-key registers and
// the voice allocator. All outputs registered, one cycle after the byte.
module ps2_poly_keymap
    import ps2_synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int OCT_W      = 3,
    parameter int OCT_RST    = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    ps2_valid,
    input  logic [7:0]              ps2_data,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic [OCT_W-1:0]        octave,
    output logic [2:0]              adsr_sel,
    output logic                    adsr_inc,
    output logic                    adsr_dec,
    output logic                    sine,
    output logic [1:0]              overdrive,
    output logic                    hold
);
    localparam logic [OCT_W-1:0] OCT_MAX = {OCT_W{1'b1}};

    ps_state_e        state_q, state_d;
    logic [7:0]       held_q, held_d;
    logic [OCT_W-1:0] octave_q, octave_d;
    logic [2:0]       adsr_sel_q, adsr_sel_d;
    logic             adsr_inc_q, adsr_inc_d;
    logic             adsr_dec_q, adsr_dec_d;
    logic             sine_q, sine_d;
    logic [1:0]       od_q, od_d;
    logic             hold_q, hold_d;

    logic       note_hit, ctl_hit, note_make, note_brk, hold_fall, ctl_new;
    logic [3:0] note_idx;
    logic [2:0] ctl_idx;

    always_comb begin
        {note_hit, note_idx} = note_lookup(ps2_data);
        {ctl_hit, ctl_idx}   = ctl_lookup(ps2_data);
        ctl_new    = ctl_hit && !held_q[ctl_idx];
        state_d    = state_q;
        held_d     = held_q;
        octave_d   = octave_q;
        adsr_sel_d = adsr_sel_q;
        adsr_inc_d = 1'b0;
        adsr_dec_d = 1'b0;
        sine_d     = sine_q;
        od_d       = od_q;
        hold_d     = hold_q;
        note_make  = 1'b0;
        note_brk   = 1'b0;
        hold_fall  = 1'b0;
        if (ps2_valid) begin
            unique case (state_q)
                PS_IDLE: begin
                    if (ps2_data == SC_EXT) begin
                        state_d = PS_EXT;
                    end else if (ps2_data == SC_BRK) begin
                        state_d = PS_BRK;
                    end else begin
                        note_make = note_hit;
                        if (ctl_new) held_d[ctl_idx] = 1'b1;
                        case (ps2_data)
                            SC_Z:   if (ctl_new && octave_q != '0) octave_d = octave_q - OCT_W'(1);
                            SC_X:   if (ctl_new && octave_q != OCT_MAX) octave_d = octave_q + OCT_W'(1);
                            SC_C:   adsr_dec_d = ctl_new;
                            SC_V:   adsr_inc_d = ctl_new;
                            SC_6:   if (ctl_new) sine_d = !sine_q;
                            SC_7:   if (ctl_new) od_d[0] = !od_q[0];
                            SC_8:   if (ctl_new) od_d[1] = !od_q[1];
                            SC_TAB: if (ctl_new) begin
                                        hold_d    = !hold_q;
                                        hold_fall = hold_q;
                                    end
                            SC_1:   adsr_sel_d = ADSR_VOL;
                            SC_2:   adsr_sel_d = ADSR_A;
                            SC_3:   adsr_sel_d = ADSR_D;
                            SC_4:   adsr_sel_d = ADSR_S;
                            SC_5:   adsr_sel_d = ADSR_R;
                            default: ;
                        endcase
                    end
                end
                PS_BRK: begin
                    state_d  = PS_IDLE;
                    note_brk = note_hit;
                    if (ctl_hit) held_d[ctl_idx] = 1'b0;
                end
                PS_EXT:     state_d = (ps2_data == SC_BRK) ? PS_EXT_BRK : PS_IDLE;
                PS_EXT_BRK: state_d = PS_IDLE;
                default:    state_d = PS_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= PS_IDLE;
            held_q     <= '0;
            octave_q   <= OCT_W'(OCT_RST);
            adsr_sel_q <= '0;
            adsr_inc_q <= 1'b0;
            adsr_dec_q <= 1'b0;
            sine_q     <= 1'b0;
            od_q       <= '0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            octave_q   <= octave_d;
            adsr_sel_q <= adsr_sel_d;
            adsr_inc_q <= adsr_inc_d;
            adsr_dec_q <= adsr_dec_d;
            sine_q     <= sine_d;
            od_q       <= od_d;
            hold_q     <= hold_d;
        end
    end

    ps2_voice_alloc #(.NUM_VOICES(NUM_VOICES)) u_alloc (
        .clk        (CLOCK_50),
        .resetn     (resetn),
        .note_make  (note_make),
        .note_brk   (note_brk),
        .note       (note_idx),
        .hold       (hold_q),
        .hold_fall  (hold_fall),
        .voice_note (voice_note),
        .voice_gate (voice_gate),
        .voice_trig (voice_trig)
    );

    assign octave    = octave_q;
    assign adsr_sel  = adsr_sel_q;
    assign adsr_inc  = adsr_inc_q;
    assign adsr_dec  = adsr_dec_q;
    assign sine      = sine_q;
    assign overdrive = od_q;
    assign hold      = hold_q;

endmodule
